add_operand_loader: RTL and testbench

ADD_OPERAND_LOADER -- requirements
Module: add_operand_loader

---
 rtl/add_operand_loader.sv | 127 ++++++++++++
 tb/tb_add_operand_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/add_operand_loader.sv
// Byte-stream operand loader for a 32-bit adder: assembles A, B and carry-in LSB-first,
// captures the adder result for one cycle, then holds it until consumed. Optional macro ADD_LOADER_OVF_EN adds res_ovf.
module add_operand_loader #(
  parameter int CIN_FROM_STREAM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_cin,
  input  logic [31:0] add_sum,
  input  logic        add_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_carry,
`ifdef ADD_LOADER_OVF_EN
  output logic        res_ovf,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {LOAD, EXEC, HOLD} state_t;

  // Index of the final byte in a frame; the carry-in byte exists only when streamed.
  localparam logic [3:0] LAST_CNT = (CIN_FROM_STREAM != 0) ? 4'd8 : 4'd7;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_cin_q, op_cin_d;
  logic [31:0] res_sum_q, res_sum_d;
  logic        res_carry_q, res_carry_d;
  logic        res_valid_q, res_valid_d;
  logic        res_ovf_q, res_ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= 4'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      op_cin_q    <= 1'b0;
      res_sum_q   <= 32'd0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_valid_d = res_valid_q;
    res_ovf_d   = res_ovf_q;
    // Flush drops progress and any pending result but leaves the operands alone.
    if (flush) begin
      state_d     = LOAD;
      cnt_d       = 4'd0;
      res_valid_d = 1'b0;
      res_ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: if (in_valid) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q[3]) begin
            if (CIN_FROM_STREAM != 0) op_cin_d = in_data[0];
          end else if (!cnt_q[2]) begin
            op_a_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
          end else begin
            op_b_d[{cnt_q[1:0], 3'b000} +: 8] = in_data;
          end
          if (cnt_q == LAST_CNT) state_d = EXEC;
        end
        EXEC: begin
          res_sum_d   = add_sum;
          res_carry_d = add_carry;
          res_ovf_d   = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = 4'd0;
          state_d     = LOAD;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = !((state_q == LOAD) && (cnt_q == 4'd0));
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_cin    = (CIN_FROM_STREAM != 0) ? op_cin_q : 1'b0;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
`ifdef ADD_LOADER_OVF_EN
  assign res_ovf   = res_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_add_operand_loader.sv
// Directed bench for add_operand_loader: streamed-cin instance plus an 8-byte-frame instance,
// each driving a behavioural 32-bit adder.
module tb_add_operand_loader;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, res_ready;
  logic [7:0]  in_data;
  logic        in_ready, op_cin, res_valid, res_carry, busy, add_carry;
  logic [31:0] op_a, op_b, add_sum, res_sum;
`ifdef ADD_LOADER_OVF_EN
  logic        res_ovf, p_res_ovf;
`endif

  logic        p_flush, p_in_valid, p_res_ready;
  logic [7:0]  p_in_data;
  logic        p_in_ready, p_op_cin, p_res_valid, p_res_carry, p_busy, p_add_carry;
  logic [31:0] p_op_a, p_op_b, p_add_sum, p_res_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_carry, add_sum}     = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
  assign {p_add_carry, p_add_sum} = {1'b0, p_op_a} + {1'b0, p_op_b} + {32'd0, p_op_cin};

  add_operand_loader #(.CIN_FROM_STREAM(1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .add_sum(add_sum),
    .add_carry(add_carry), .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry),
`ifdef ADD_LOADER_OVF_EN
    .res_ovf(res_ovf),
`endif
    .busy(busy));

  add_operand_loader #(.CIN_FROM_STREAM(0)) u1 (
    .clk(clk), .rst(rst), .flush(p_flush), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .op_a(p_op_a), .op_b(p_op_b), .op_cin(p_op_cin), .add_sum(p_add_sum),
    .add_carry(p_add_carry), .res_valid(p_res_valid), .res_ready(p_res_ready), .res_sum(p_res_sum),
    .res_carry(p_res_carry),
`ifdef ADD_LOADER_OVF_EN
    .res_ovf(p_res_ovf),
`endif
    .busy(p_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // cin byte carries junk in bits 7:1 to show they are ignored.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic cin);
    for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[i*8 +: 8]);
    send_byte({7'b1010101, cin});
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = 8'h00; p_res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_res_sum", res_sum, 0);

    // Basic add with latency and backpressure
    send_frame(32'h000000FF, 32'h00000001, 1'b0);
    chk("basic_exec_valid", res_valid, 0);
    chk("basic_exec_ready", in_ready, 0);
    chk("basic_exec_busy", busy, 1);
    tick();
    chk("basic_valid", res_valid, 1);
    chk("basic_sum", res_sum, 32'h00000100);
    chk("basic_carry", res_carry, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", res_sum, 32'h00000100);
      chk("bp_in_ready", in_ready, 0);
    end
    handshake();
    chk("hs_valid", res_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);

    // Carry chain through all 32 bits
    send_frame(32'hFFFFFFFF, 32'h00000000, 1'b1);
    chk("cc_op_cin", op_cin, 1);
    tick();
    chk("cc_sum", res_sum, 32'h00000000);
    chk("cc_carry", res_carry, 1);
    chk("cc_valid", res_valid, 1);
    handshake();

    // Signed overflow
    send_frame(32'h7FFFFFFF, 32'h00000001, 1'b0);
    tick();
    chk("ov_sum", res_sum, 32'h80000000);
    chk("ov_carry", res_carry, 0);
`ifdef ADD_LOADER_OVF_EN
    chk("ov_ovf", res_ovf, 1);
`endif
    handshake();

    // Flush after 5 bytes, then a full frame yields exactly one result
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    chk("pf_busy", busy, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_result", res_valid, 0);
    end
    send_frame(32'h00000003, 32'h00000004, 1'b0);
    chk("fl2_exec_valid", res_valid, 0);
    tick();
    chk("fl2_valid", res_valid, 1);
    chk("fl2_sum", res_sum, 32'h00000007);

    // Flush while holding a result; operands untouched
    flush = 1'b1; res_ready = 1'b1; tick(); flush = 1'b0; res_ready = 1'b0;
    chk("flh_valid", res_valid, 0);
    chk("flh_in_ready", in_ready, 1);
    chk("flh_op_a", op_a, 32'h00000003);
    chk("flh_op_b", op_b, 32'h00000004);

    // Flush beats a simultaneous byte
    flush = 1'b1; send_byte(8'h77); flush = 1'b0;
    chk("flb_busy", busy, 0);
    chk("flb_op_a", op_a, 32'h00000003);

    // Reset mid-frame discards everything
    for (int i = 0; i < 3; i++) send_byte(8'hC3);
    rst = 1'b1; flush = 1'b1; tick(); rst = 1'b0; flush = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_op_a", op_a, 0);
    chk("mr_in_ready", in_ready, 1);

    // 8-byte frame instance, carry-in tied low
    for (int i = 0; i < 8; i++) begin
      logic [63:0] fr;
      fr = {32'h11111111, 32'h12345678};
      p_in_valid = 1'b1;
      p_in_data  = fr[i*8 +: 8];
      tick();
    end
    p_in_valid = 1'b0;
    chk("p0_exec_ready", p_in_ready, 0);
    chk("p0_exec_valid", p_res_valid, 0);
    chk("p0_op_cin", p_op_cin, 0);
    tick();
    chk("p0_valid", p_res_valid, 1);
    chk("p0_sum", p_res_sum, 32'h23456789);
    chk("p0_carry", p_res_carry, 0);
    p_res_ready = 1'b1; tick(); p_res_ready = 1'b0;
    chk("p0_hs_ready", p_in_ready, 1);
    chk("p0_hs_busy", p_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
